fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin, packet-atomic write arbiter that shares the single write port of the 16-entry, 8-bit FIFO memory between N independent producers. Once a producer is granted, it owns the port until its `last` beat is accepted, a beat-count limit truncates the packet, or an idle timeout expires. The block drives the FIFO's `wr`/`data_in` directly and throttles producers on `fifo_full`. It sits between the producer ports and the FIFO; the read side is untouched.

## Interface
- `N`, 4: number of requesters; legal range 2..8. `IDW = $clog2(N)`.
- `DW`, 8: data width; must match the FIFO data width.
- `MAX_PKT`, 16: maximum beats per grant before forced release; legal range 1..255.
- `IDLE_TO`, 8: consecutive cycles without `req` from the granted port before forced release; legal range 1..255.
- `clk`  in  1  Single clock, rising edge.
- `rst`  in  1  Reset. Asynchronous, active-high.
- `req`  in  N  Per-port "beat valid" request.
- `last`  in  N  Per-port end-of-packet flag, qualified by `req`.
- `data`  in  N*DW  Port i data in bits `[i*DW +: DW]`.
- `ack`  out  N  Per-port "beat accepted" strobe (one-hot or zero).
- `fifo_full`  in  1  From the FIFO status logic.
- `fifo_wr`  out  1  FIFO write strobe.
- `fifo_data`  out  DW  FIFO write data.
- `grant_vld`  out  1  A port currently owns the FIFO.
- `grant_id`  out  IDW  Owning port index.
- `trunc`  out  1  One-cycle pulse: grant released by the `MAX_PKT` limit.
- `timeout`  out  1  One-cycle pulse: grant released by `IDLE_TO`.

## Operation
- Two states: IDLE and XFER. The state register, `grant_id`, round-robin pointer `rr_ptr` (IDW bits), beat counter (8 bits), idle counter (8 bits), `trunc`, and `timeout` are all registered.
- IDLE:
  - If any `req` bit is set, select the first set bit searching `rr_ptr`, `rr_ptr+1`, … mod N.
  - Load `grant_id`, clear both counters, go to XFER.
  - Otherwise stay in IDLE.
- XFER: `beat = req[grant_id] & ~fifo_full`.
  - `fifo_wr = beat`, `fifo_data = data[grant_id]`, `ack[grant_id] = beat`; all other `ack` bits are 0. These outputs are combinational from registered grant state and the inputs.
  - On a beat: increment the beat counter and clear the idle counter.
  - Release on a beat with `last[grant_id]` set: go to IDLE, `rr_ptr <= grant_id + 1` mod N.
  - Release when a beat brings the counter to `MAX_PKT` with `last` clear: same as above, plus `trunc` pulses in the next cycle.
  - If `req[grant_id] = 0`: increment the idle counter. When it reaches `IDLE_TO`, release as above and pulse `timeout`.
  - If `req[grant_id] = 1` but `fifo_full` blocks the beat: the idle counter holds, because backpressure is not idleness.
- `grant_vld` = (state == XFER).
- In IDLE: `fifo_wr`, `ack`, and `grant_vld` are 0. `fifo_data` equals `data[grant_id]` but is don't-care.
- `req`/`last` on non-granted ports are ignored. Those ports see `ack` = 0 and must hold their beat.
- No beat is ever issued while `fifo_full` = 1. The arbiter therefore never causes FIFO overflow.

## Timing
- Reset (asynchronous, effective immediately):
  - State IDLE, `rr_ptr` 0, `grant_id` 0, counters 0.
  - `grant_vld`, `fifo_wr`, `ack`, `trunc`, `timeout` all 0.
  - Assertion mid-packet drops `fifo_wr` in the same cycle. The partial packet is abandoned.
- Grant latency: `req` sampled in IDLE at edge k → `grant_vld` = 1 after edge k. The first `fifo_wr` can occur in cycle k+1.
- Throughput: one beat per cycle while granted, `req` held, and not full.
- Turnaround: the cycle after a release is always IDLE. The next grant takes effect one edge later, giving at least one dead cycle between packets.
- Simultaneous `last` and `MAX_PKT` on the same beat: normal release, no `trunc`.
- `fifo_full` in the same cycle as the `last` request: no beat; the grant holds.
- `rr_ptr` wraps N-1 → 0.

## Test plan
- Single port: reset, port 2 sends 3 beats (`last` on the third, FIFO empty) → `grant_id` = 2 one cycle after `req`; `fifo_wr` high for 3 cycles; `ack` = 4'b0100 for those cycles; `rr_ptr` = 3.
- Fairness: all four ports request continuously with 2-beat packets → grant order 0,1,2,3,0; every packet is contiguous with no interleaving; one IDLE cycle between packets.
- Backpressure: hold `fifo_full` = 1 for 5 cycles mid-packet → `fifo_wr`/`ack` = 0 for those cycles; no `timeout`; transfer resumes when `fifo_full` falls; no beats are lost, since the bench checks FIFO contents.
- Truncation: with `MAX_PKT` = 16, port 1 streams 20 beats with no `last` → exactly 16 writes, then a `trunc` pulse; port 1 is re-granted only after other requesters if any are pending.
- Timeout: port 0 is granted, sends 1 beat, then drops `req` for 8 cycles → `timeout` pulses; state IDLE; port 3, pending, is granted next.
- Reset mid-packet: assert `rst` during beat 2 of 4 → `fifo_wr`, `grant_vld` = 0 immediately; after release, the first grant goes to the lowest pending port index.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Producer-side and FIFO-side signals of the packet-atomic write arbiter.
// The master modport is the environment (producers plus FIFO status).
// The slave modport is the arbiter itself.
interface fifo_wr_arb_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ack;
  logic            fifo_full;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_data;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic            trunc;
  logic            timeout;

  modport master (
    output req, last, data, fifo_full,
    input  ack, fifo_wr, fifo_data, grant_vld, grant_id, trunc, timeout
  );

  modport slave (
    input  req, last, data, fifo_full,
    output ack, fifo_wr, fifo_data, grant_vld, grant_id, trunc, timeout
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin, packet-atomic arbiter for the single FIFO write port.
// A granted producer keeps the port until its last beat is accepted.
// The grant is also released when MAX_PKT beats are reached or IDLE_TO idle cycles elapse.
module fifo_wr_arb #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int MAX_PKT = 16,
  parameter int IDLE_TO = 8
) (
  input  logic         clk,
  input  logic         rst,
  fifo_wr_arb_if.slave bus
);
  localparam int             IDW       = $clog2(N);
  localparam logic [7:0]     MAX_PKT_C = 8'(MAX_PKT);
  localparam logic [7:0]     IDLE_TO_C = 8'(IDLE_TO);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] grant_id, rr_ptr, next_ptr;
  logic [IDW-1:0] pick_id, cand;
  logic           pick_vld;
  logic [7:0]     beat_cnt, idle_cnt, beat_cnt_inc, idle_cnt_inc;
  logic           req_g, last_g, beat;
  logic           rel_last, rel_trunc, rel_idle, rel_any;
  logic           trunc_q, timeout_q;

  // Beat qualification and the three release causes for the owning port.
  assign req_g        = bus.req[grant_id];
  assign last_g       = bus.last[grant_id];
  assign beat         = (state == XFER) && req_g && !bus.fifo_full;
  assign beat_cnt_inc = beat_cnt + 8'd1;
  assign idle_cnt_inc = idle_cnt + 8'd1;
  assign rel_last     = beat && last_g;
  // A beat that carries last and also hits the limit is a normal release with no trunc.
  assign rel_trunc    = beat && !last_g && (beat_cnt_inc == MAX_PKT_C);
  assign rel_idle     = (state == XFER) && !req_g && (idle_cnt_inc == IDLE_TO_C);
  assign rel_any      = rel_last || rel_trunc || rel_idle;
  assign next_ptr     = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  // Round-robin search: first requesting port at or after rr_ptr, wrapping modulo N.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    pick_vld = 1'b0;
    pick_id  = rr_ptr;
    cand     = rr_ptr;
    for (int k = 0; k < N; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % N);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignment, so all flops update together at the edge.
    else     state <= state_nxt;
  end

  // Next-state: IDLE grants on any request; XFER returns to IDLE on any release.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pick_vld) state_nxt = XFER;
      XFER: if (rel_any)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant owner, round-robin pointer, beat/idle counters and the release pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id  <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      trunc_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      trunc_q   <= rel_trunc;
      timeout_q <= rel_idle;
      if (state == IDLE) begin
        if (pick_vld) begin
          grant_id <= pick_id;
          beat_cnt <= '0;
          idle_cnt <= '0;
        end
      end else begin
        if (beat) begin
          beat_cnt <= beat_cnt_inc;
          idle_cnt <= '0;
        end else if (!req_g) begin
          idle_cnt <= idle_cnt_inc;
        end
        // A request blocked only by fifo_full leaves idle_cnt unchanged: backpressure is not idleness.
        if (rel_any) rr_ptr <= next_ptr;
      end
    end
  end

  // Outputs: write strobe, data mux and ack come straight from the registered grant and the inputs.
  always_comb begin
    bus.ack            = '0;
    bus.ack[grant_id]  = beat;
    bus.fifo_wr        = beat;
    bus.fifo_data      = bus.data[grant_id*DW +: DW];
    bus.grant_vld      = (state == XFER);
    bus.grant_id       = grant_id;
    bus.trunc          = trunc_q;
    bus.timeout        = timeout_q;
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb.
// It uses a constant vector table, hand-built packet scenarios, and a randomized phase.
// Every phase is checked against a cycle-level behavioural model.
module tb_fifo_wr_arb;
  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int MAX_PKT = 16;
  localparam int IDLE_TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(.N(N), .DW(DW)) bus ();

  fifo_wr_arb #(.N(N), .DW(DW), .MAX_PKT(MAX_PKT), .IDLE_TO(IDLE_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic gv, input logic [1:0] gid, input logic wr,
                                       input logic [3:0] a, input logic tr, input logic to,
                                       input logic [7:0] fd);
    return {14'd0, gv, gid, wr, a, tr, to, (wr ? fd : 8'h00)};
  endfunction

  function automatic logic [31:0] dut_pack();
    return pack(bus.grant_vld, bus.grant_id, bus.fifo_wr, bus.ack, bus.trunc, bus.timeout,
                bus.fifo_data);
  endfunction

  // ---------------- behavioural model ----------------
  int m_owner, m_gid, m_ptr, m_beats, m_idle;
  bit m_trunc, m_to;

  function automatic void model_reset();
    m_owner = -1; m_gid = 0; m_ptr = 0; m_beats = 0; m_idle = 0;
    m_trunc = 0;  m_to = 0;
  endfunction

  function automatic logic [31:0] model_out();
    logic wr; logic [3:0] a; logic [7:0] fd;
    wr = 1'b0; a = '0; fd = '0;
    if (m_owner >= 0) begin
      wr = bus.req[m_owner] && !bus.fifo_full;
      if (wr) begin
        a[m_owner] = 1'b1;
        fd = bus.data[m_owner*DW +: DW];
      end
    end
    return pack(m_owner >= 0, 2'(m_gid), wr, a, m_trunc, m_to, fd);
  endfunction

  function automatic void model_step();
    bit t, to, done, found;
    t = 0; to = 0; done = 0; found = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && bus.req[j]) begin
          found = 1; m_owner = j; m_gid = j; m_beats = 0; m_idle = 0;
        end
      end
    end else begin
      if (bus.req[m_owner] && !bus.fifo_full) begin
        m_beats++; m_idle = 0;
        if (bus.last[m_owner]) done = 1;
        else if (m_beats == MAX_PKT) begin done = 1; t = 1; end
      end else if (!bus.req[m_owner]) begin
        m_idle++;
        if (m_idle == IDLE_TO) begin done = 1; to = 1; end
      end
      if (done) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    m_trunc = t; m_to = to;
  endfunction

  // ---------------- producers and bookkeeping ----------------
  int p_cnt[N], p_total[N], p_len[N];
  bit full_v, rand_mode;
  int dens;
  int wr_cnt, trunc_cnt, to_cnt, tk, wr_at_trunc, to_at;
  bit prev_gv;
  logic [7:0] act_q[$];
  logic [7:0] exp_q[$];
  int grants[$];

  task automatic drive();
    logic [3:0] r, l; logic [31:0] d;
    r = '0; l = '0; d = '0;
    if (rand_mode) begin
      dens = ((tk / 100) % 2 == 1) ? 1 : 6;
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(7) < dens);
        l[i] = ($urandom_range(19) == 0);
      end
      d = $urandom;
      bus.fifo_full = ($urandom_range(3) == 0);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (p_cnt[i] < p_total[i]) begin
          r[i] = 1'b1;
          l[i] = (p_len[i] != 0) && (p_cnt[i] % p_len[i] == p_len[i] - 1);
        end
        d[i*DW +: DW] = 8'(i * 64 + p_cnt[i]);
      end
      bus.fifo_full = full_v;
    end
    bus.req = r; bus.last = l; bus.data = d;
  endtask

  task automatic clear_book();
    wr_cnt = 0; trunc_cnt = 0; to_cnt = 0; tk = 0; prev_gv = 0;
    wr_at_trunc = -1; to_at = -1;
    act_q.delete(); exp_q.delete(); grants.delete();
  endtask

  task automatic clear_prod();
    for (int i = 0; i < N; i++) begin p_cnt[i] = 0; p_total[i] = 0; p_len[i] = 0; end
    full_v = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    model_reset();
    clear_book();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive();
  endtask

  // One clock: compare at the falling edge, advance the model, then drive at posedge+1.
  task automatic tick(input string tag);
    logic [3:0] ackv;
    @(negedge clk);
    check($sformatf("%s_c%0d", tag, tk), dut_pack(), model_out());
    if (bus.fifo_wr) begin wr_cnt++; act_q.push_back(bus.fifo_data); end
    if (bus.trunc) begin
      if (trunc_cnt == 0) wr_at_trunc = wr_cnt;
      trunc_cnt++;
    end
    if (bus.timeout) begin to_cnt++; to_at = tk; end
    if (bus.grant_vld && !prev_gv) grants.push_back(int'(bus.grant_id));
    prev_gv = bus.grant_vld;
    ackv = bus.ack;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (ackv[i]) p_cnt[i]++;
    tk++;
    drive();
  endtask

  task automatic check_seq(input string name, input int got[$], input int exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s_%0d", name, i), got[i], exp[i]);
  endtask

  task automatic check_bytes(input string name);
    check({name, "_len"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_%0d", name, i), act_q[i], exp_q[i]);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  last;
    logic        full;
    logic [31:0] dat;
    logic        gv;
    logic [1:0]  gid;
    logic        wr;
    logic [3:0]  ack;
    logic [7:0]  fd;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                               input logic gv, input logic [1:0] gid, input logic wr,
                               input logic [3:0] a, input logic [7:0] fd);
    vec_t v;
    v.req = r; v.last = l; v.full = 1'b0; v.dat = d;
    v.gv = gv; v.gid = gid; v.wr = wr; v.ack = a; v.fd = fd;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    // Port 2 sends 3 beats, then ports 3 and 1 show the pointer moved to 3.
    tbl[0]  = mkv(4'b0000, 4'b0000, 32'hD3A0D1D0, 0, 2'd0, 0, 4'b0000, 8'h00);
    tbl[1]  = mkv(4'b0100, 4'b0000, 32'hD3A0D1D0, 0, 2'd0, 0, 4'b0000, 8'h00);
    tbl[2]  = mkv(4'b0100, 4'b0000, 32'hD3A0D1D0, 1, 2'd2, 1, 4'b0100, 8'hA0);
    tbl[3]  = mkv(4'b0100, 4'b0000, 32'hD3A1D1D0, 1, 2'd2, 1, 4'b0100, 8'hA1);
    tbl[4]  = mkv(4'b0100, 4'b0100, 32'hD3A2D1D0, 1, 2'd2, 1, 4'b0100, 8'hA2);
    tbl[5]  = mkv(4'b0000, 4'b0000, 32'hD3A2D1D0, 0, 2'd2, 0, 4'b0000, 8'h00);
    tbl[6]  = mkv(4'b1010, 4'b1010, 32'hD3A2D1D0, 0, 2'd2, 0, 4'b0000, 8'h00);
    tbl[7]  = mkv(4'b1010, 4'b1010, 32'hD3A2D1D0, 1, 2'd3, 1, 4'b1000, 8'hD3);
    tbl[8]  = mkv(4'b0010, 4'b0010, 32'hD3A2D1D0, 0, 2'd3, 0, 4'b0000, 8'h00);
    tbl[9]  = mkv(4'b0010, 4'b0010, 32'hD3A2D1D0, 1, 2'd1, 1, 4'b0010, 8'hD1);
    tbl[10] = mkv(4'b0000, 4'b0000, 32'hD3A2D1D0, 0, 2'd1, 0, 4'b0000, 8'h00);

    rand_mode = 0;
    clear_prod();
    bus.req = '0; bus.last = '0; bus.data = '0; bus.fifo_full = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.req = tbl[i].req; bus.last = tbl[i].last;
      bus.data = tbl[i].dat; bus.fifo_full = tbl[i].full;
      @(negedge clk);
      check($sformatf("vec%0d", i), dut_pack(),
            pack(tbl[i].gv, tbl[i].gid, tbl[i].wr, tbl[i].ack, 1'b0, 1'b0, tbl[i].fd));
      @(posedge clk);
      #1;
    end

    // Fairness: four ports, 2-beat packets, two packets each.
    clear_prod();
    for (int i = 0; i < N; i++) begin p_total[i] = 4; p_len[i] = 2; end
    reset_dut();
    repeat (40) tick("fair");
    check_seq("fair_order", grants, '{0, 1, 2, 3, 0, 1, 2, 3});
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        for (int b = 0; b < 2; b++) exp_q.push_back(8'(i * 64 + 2 * r + b));
    check_bytes("fair_data");

    // Backpressure: fifo_full held for 10 cycles mid-packet, longer than IDLE_TO.
    clear_prod();
    p_total[0] = 6; p_len[0] = 6;
    reset_dut();
    for (int g = 0; g < 20 && p_cnt[0] < 2; g++) tick("bp_pre");
    full_v = 1; bus.fifo_full = 1'b1;
    begin
      int w0;
      w0 = wr_cnt;
      repeat (10) tick("bp_full");
      check("bp_no_wr_when_full", wr_cnt - w0, 0);
    end
    full_v = 0; bus.fifo_full = 1'b0;
    repeat (12) tick("bp_post");
    check("bp_no_timeout", to_cnt, 0);
    for (int b = 0; b < 6; b++) exp_q.push_back(8'(b));
    check_bytes("bp_data");

    // Truncation: port 1 streams 20 beats with no last; port 3 is pending.
    clear_prod();
    p_total[1] = 20; p_len[1] = 0;
    p_total[3] = 1;  p_len[3] = 1;
    reset_dut();
    repeat (45) tick("trunc");
    check("trunc_pulses", trunc_cnt, 1);
    check("trunc_writes_before", wr_at_trunc, MAX_PKT);
    check("trunc_total_writes", wr_cnt, 21);
    check_seq("trunc_order", grants, '{1, 3, 1});

    // Timeout: port 0 sends one beat without last, then goes quiet; port 3 waits.
    clear_prod();
    p_total[0] = 1; p_len[0] = 0;
    p_total[3] = 1; p_len[3] = 1;
    reset_dut();
    repeat (16) tick("to");
    check("to_pulses", to_cnt, 1);
    check("to_cycle", to_at, 10);
    check("to_no_trunc", trunc_cnt, 0);
    check_seq("to_order", grants, '{0, 3});
    exp_q.push_back(8'h00); exp_q.push_back(8'hC0);
    check_bytes("to_data");

    // Reset mid-packet: move rr_ptr to 3, then reset during beat 2 of a 4-beat packet.
    clear_prod();
    p_total[2] = 1; p_len[2] = 1;
    reset_dut();
    repeat (4) tick("rst_pre");
    p_total[2] = 5; p_len[2] = 0;
    drive();
    for (int g = 0; g < 10 && p_cnt[2] < 2; g++) tick("rst_pkt");
    @(negedge clk);
    check("rst_wr_before", bus.fifo_wr, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_wr_drop", bus.fifo_wr, 1'b0);
    check("rst_gv_drop", bus.grant_vld, 1'b0);
    check("rst_ack_drop", bus.ack, 4'b0000);
    clear_prod();
    for (int i = 1; i < N; i++) begin p_total[i] = 1; p_len[i] = 1; end
    model_reset();
    clear_book();
    @(posedge clk);
    #1 rst = 1'b0;
    drive();
    repeat (12) tick("rst_post");
    check_seq("rst_order", grants, '{1, 2, 3});

    // Randomized traffic against the model.
    clear_prod();
    reset_dut();
    rand_mode = 1;
    drive();
    repeat (600) tick("rand");
    rand_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
